seq_term_arbiter: RTL and testbench
===================================

Name: seq_term_arbiter

Overview:
- Shared on-demand term engine for the sequence 1 0 1 1 1 2 2 3 4 5 7 9 12 16 …
  - s[0]=1, s[1]=0, s[2]=1
  - s[n]=s[n-2]+s[n-3]
- Contains one iterative three-register recurrence datapath plus the FSM that sequences it.
- Requesters submit a term index; the block arbitrates round-robin, iterates the datapath, and returns s[idx] on a shared response channel.
- Used wherever several clients need sequence terms without each instantiating a free-running generator.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- IDX_W, 8, width of the requested term index.
- DATA_W, 32, width of term values.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_valid_i  input  NUM_REQ  per-requester request valid.
- req_idx_i  input  NUM_REQ*IDX_W  per-requester term index; requester i occupies bits [i*IDX_W +: IDX_W].
- req_ready_o  output  NUM_REQ  per-requester accept; at most one bit high.
- rsp_valid_o  output  1  response valid.
- rsp_id_o  output  $clog2(NUM_REQ)  requester the response belongs to.
- rsp_data_o  output  DATA_W  s[idx].
- rsp_ready_i  input  1  response consumer ready.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high.
- Reset values:
  - FSM=IDLE, rr_ptr=0.
  - rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, busy_o=0.
  - req_ready_o=0 except as given by the IDLE grant logic.
- Reset asserted mid-operation discards the in-flight request; no response is ever emitted for it.

IDLE:
- grant = first i with req_valid_i[i], searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- req_ready_o[grant]=1 combinationally. All other ready bits are 0; all are 0 if no request is valid.
- Requesters must not make valid depend on ready.
- On handshake:
  - Capture idx and id=grant.
  - Load datapath r0=0, r1=0, r2=1; cnt=0.
  - Go to RUN.

RUN:
- If cnt==idx: rsp_data_o<=r2, rsp_valid_o<=1, go to RESP.
- Else: r0<=r1, r1<=r2, r2<=r0+r1, cnt<=cnt+1.
- Addition is modulo 2^DATA_W; wrap is silent, with no saturation and no flag.
- cnt is IDX_W+1 bits, so it never wraps before matching.

RESP:
- rsp_valid_o, rsp_id_o and rsp_data_o are held stable until rsp_valid_o && rsp_ready_i.
- On that handshake: rsp_valid_o<=0, rr_ptr<=(id+1) mod NUM_REQ, go to IDLE.
- req_ready_o is all 0 in RUN and RESP.

Latency:
- Handshake in cycle T gives rsp_valid_o high from cycle T+idx+2.
- Throughput is one request per (idx+3) cycles minimum, because IDLE costs one cycle between jobs.

Boundary conditions:
- idx=0: the response is 1 at T+2.
- Simultaneous requests: the lower index at or after rr_ptr wins. The loser stays pending and must hold valid and idx stable.
- A requester dropping valid before its grant is legal and is not recorded.
- rsp_ready_i high in the same cycle rsp_valid_o rises: completes in that cycle, and IDLE follows next cycle.
- Change of req_idx_i after the handshake has no effect.

Optional Feature:
- Macro: SEQ_TERM_ARB_ABORT_EN.
- Defined:
  - Adds port abort_i (input, 1) after rsp_ready_i.
  - abort_i high in RUN or RESP: next cycle FSM=IDLE, rsp_valid_o=0, no response for the aborted job, rr_ptr<=(id+1) mod NUM_REQ.
  - abort_i in IDLE is ignored; a handshake in the same cycle still occurs.
  - reset has priority over abort_i.
- Undefined: the port is absent; every accepted request produces exactly one response.

Test Plan:
- Single request, idx 0:
  - req0 idx=0 at cycle T -> ready0=1 at T.
  - At T+2: rsp_valid=1, id=0, data=1.
  - busy_o high T+1..T+2.
- Single request, idx 12:
  - req1 idx=12 -> data=12 at T+14.
  - Repeat for idx 3/5/10/13 -> 1/2/7/16.
- Contention:
  - Both valid from reset, idx 4 and 9 -> req0 served first (data 1), then req1 (data 5).
  - Next simultaneous pair -> req1 first (pointer rotation).
- Back-pressure:
  - rsp_ready_i low 5 cycles after rsp_valid -> data/id stable, no new ready.
  - Accept on cycle 6 -> IDLE next cycle.
- Wrap:
  - idx=255, DATA_W=32 -> data equals reference model value mod 2^32.
  - Latency 257 cycles.
- Reset mid-RUN:
  - reset at T+5 of idx=50 job -> no response; all outputs at reset values next cycle; rr_ptr=0.
- Abort (with SEQ_TERM_ARB_ABORT_EN):
  - abort_i during RUN -> no response.
  - Then the other requester is granted.

Source files
------------

// File: rtl/seq_term_arbiter.sv
// Shared round-robin term engine for s[n]=s[n-2]+s[n-3] (s0=1, s1=0, s2=1).
// Optional abort port enabled by defining SEQ_TERM_ARB_ABORT_EN.
module seq_term_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 8,
  parameter int DATA_W  = 32,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     rsp_valid_o,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic [DATA_W-1:0]        rsp_data_o,
  input  logic                     rsp_ready_i,
`ifdef SEQ_TERM_ARB_ABORT_EN
  input  logic                     abort_i,
`endif
  output logic                     busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_r;
  state_e              state_nxt_s;
  logic [ID_W-1:0]     rr_ptr_r;
  logic [ID_W-1:0]     id_r;
  logic [ID_W-1:0]     grant_s;
  logic [ID_W-1:0]     cand_s;
  logic                grant_vld_s;
  logic [IDX_W-1:0]    idx_r;
  logic [IDX_W:0]      cnt_r;
  logic [DATA_W-1:0]   r0_r;
  logic [DATA_W-1:0]   r1_r;
  logic [DATA_W-1:0]   r2_r;
  logic                rsp_valid_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic                busy_r;
  logic                abort_s;
  logic                done_s;
  logic                load_s;
  logic                step_s;
  logic                emit_s;
  logic                release_s;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] p);
    if (p == ID_W'(NUM_REQ - 1)) begin
      return {ID_W{1'b0}};
    end else begin
      return p + ID_W'(1'b1);
    end
  endfunction

`ifdef SEQ_TERM_ARB_ABORT_EN
  assign abort_s = abort_i;
`else
  assign abort_s = 1'b0;
`endif

  assign done_s      = (cnt_r == {1'b0, idx_r});
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_id_o    = id_r;
  assign rsp_data_o  = rsp_data_r;
  assign busy_o      = busy_r;

  // Round-robin search: first valid requester at or after rr_ptr.
  always_comb begin
    grant_s     = rr_ptr_r;
    grant_vld_s = 1'b0;
    cand_s      = rr_ptr_r;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_vld_s && req_valid_i[cand_s]) begin
        grant_s     = cand_s;
        grant_vld_s = 1'b1;
      end else begin
        grant_s     = grant_s;
      end
      cand_s = wrap_inc(cand_s);
    end
  end

  // Next-state and per-cycle datapath controls.
  always_comb begin
    state_nxt_s = state_r;
    req_ready_o = {NUM_REQ{1'b0}};
    load_s      = 1'b0;
    step_s      = 1'b0;
    emit_s      = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_vld_s) begin
          req_ready_o[grant_s] = 1'b1;
          load_s               = 1'b1;
          state_nxt_s          = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_s) begin
          release_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (done_s) begin
          emit_s      = 1'b1;
          state_nxt_s = ST_RESP;
        end else begin
          step_s      = 1'b1;
          state_nxt_s = ST_RUN;
        end
      end
      ST_RESP: begin
        if (abort_s || rsp_ready_i) begin
          release_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register; busy mirrors the next state so it is itself a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // Job capture, recurrence iteration and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r    <= {ID_W{1'b0}};
      id_r        <= {ID_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      cnt_r       <= {(IDX_W+1){1'b0}};
      r0_r        <= {DATA_W{1'b0}};
      r1_r        <= {DATA_W{1'b0}};
      r2_r        <= {DATA_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
    end else begin
      if (load_s) begin
        id_r  <= grant_s;
        idx_r <= req_idx_i[int'(grant_s)*IDX_W +: IDX_W];
        cnt_r <= {(IDX_W+1){1'b0}};
        r0_r  <= {DATA_W{1'b0}};
        r1_r  <= {DATA_W{1'b0}};
        r2_r  <= {{(DATA_W-1){1'b0}}, 1'b1};
      end
      // r2 holds s[cnt]; the next term reuses the two older ones, wrapping silently.
      if (step_s) begin
        r0_r  <= r1_r;
        r1_r  <= r2_r;
        r2_r  <= r0_r + r1_r;
        cnt_r <= cnt_r + {{IDX_W{1'b0}}, 1'b1};
      end
      if (emit_s) begin
        rsp_data_r  <= r2_r;
        rsp_valid_r <= 1'b1;
      end
      if (release_s) begin
        rsp_valid_r <= 1'b0;
        rr_ptr_r    <= wrap_inc(id_r);
      end
    end
  end

endmodule

// File: tb/tb_seq_term_arbiter.sv
// Randomized + directed bench for seq_term_arbiter with a cycle-level job model.
module tb_seq_term_arbiter;
  localparam int N  = 2;
  localparam int IW = 8;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*IW-1:0] req_idx;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [0:0]      rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            rsp_ready;
  logic            busy;
  logic            abort;

  always #5 clk = ~clk;

  seq_term_arbiter #(.NUM_REQ(N), .IDX_W(IW), .DATA_W(DW)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid_i(req_valid),
    .req_idx_i(req_idx),
    .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid),
    .rsp_id_o(rsp_id),
    .rsp_data_o(rsp_data),
    .rsp_ready_i(rsp_ready),
`ifdef SEQ_TERM_ARB_ABORT_EN
    .abort_i(abort),
`endif
    .busy_o(busy)
  );

  logic [DW-1:0] sref [0:255];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Job model: phase 0 idle, 1 computing (m_left cycles remain), 2 responding.
  int            m_phase = 0;
  int            m_left  = 0;
  int            m_id    = 0;
  int            m_idx   = 0;
  int            m_ptr   = 0;
  logic [DW-1:0] m_data  = '0;
  bit            m_chk   = 1'b0;
  bit            m_post  = 1'b0;
  logic [N-1:0]  m_hs    = '0;
  int            hs_cyc [N];
  bit            obs_valid;
  bit            obs_busy;
  int            obs_id;
  logic [DW-1:0] obs_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int grant_of(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic cycle();
    int g;
    logic [N-1:0] er;
    @(negedge clk);
    cyc++;
    obs_valid = rsp_valid;
    obs_busy  = busy;
    obs_id    = int'(rsp_id);
    obs_data  = rsp_data;
    g  = grant_of(req_valid, m_ptr);
    er = '0;
    if (m_phase == 0 && g >= 0) er[g] = 1'b1;
    if (m_chk) begin
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("busy", 64'(busy), 64'(m_phase != 0));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
      if (m_phase == 2) begin
        chk("rsp_id", 64'(rsp_id), 64'(m_id));
        chk("rsp_data", 64'(rsp_data), 64'(m_data));
      end
      if (m_post) begin
        chk("rst_id", 64'(rsp_id), 64'(0));
        chk("rst_data", 64'(rsp_data), 64'(0));
      end
    end
    m_hs = '0;
    if (reset) begin
      m_phase = 0; m_ptr = 0; m_post = 1'b1; m_chk = 1'b1;
    end else begin
      m_post = 1'b0;
      if (m_phase != 0 && abort) begin
        m_phase = 0; m_ptr = (m_id + 1) % N;
      end else if (m_phase == 0) begin
        if (g >= 0) begin
          m_hs[g] = 1'b1; m_id = g; m_idx = int'(req_idx[g*IW +: IW]);
          m_left = m_idx + 1; m_phase = 1; hs_cyc[g] = cyc;
        end
      end else if (m_phase == 1) begin
        if (m_left == 1) begin
          m_phase = 2; m_data = sref[m_idx];
        end else begin
          m_left--;
        end
      end else if (rsp_ready) begin
        m_phase = 0; m_ptr = (m_id + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    cycle();
    for (int i = 0; i < N; i++) if (m_hs[i]) req_valid[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input int idx);
    req_idx[i*IW +: IW] = IW'(idx);
    req_valid[i] = 1'b1;
  endtask

  task automatic expect_rsp(input string nm, input int id, input logic [DW-1:0] data, input int lat);
    bit ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      step();
      ok = obs_valid;
    end
    if (!ok) begin
      chk({nm, "_timeout"}, 64'(0), 64'(1));
    end else begin
      chk({nm, "_id"}, 64'(obs_id), 64'(id));
      chk({nm, "_data"}, 64'(obs_data), 64'(data));
      if (lat >= 0) chk({nm, "_lat"}, 64'(cyc - hs_cyc[id]), 64'(lat));
    end
  endtask

  initial begin
    int ti [4] = '{3, 5, 10, 13};
    int td [4] = '{1, 2, 7, 16};
    int cnt;
    bit got;
    reset = 1'b1; req_valid = '0; req_idx = '0; rsp_ready = 1'b1; abort = 1'b0;
    sref[0] = 1; sref[1] = 0; sref[2] = 1;
    for (int n = 3; n < 256; n++) sref[n] = sref[n-2] + sref[n-3];
    chk("sref0", 64'(sref[0]), 64'(1));
    chk("sref9", 64'(sref[9]), 64'(5));
    chk("sref13", 64'(sref[13]), 64'(16));

    // Reset state
    cycle(); cycle();
    reset = 1'b0;
    cycle(); cycle();
    chk("idle_busy", 64'(obs_busy), 64'(0));

    // Single requests
    set_req(0, 0);
    expect_rsp("idx0", 0, 1, 2);
    set_req(1, 12);
    expect_rsp("idx12", 1, 12, 14);
    for (int k = 0; k < 4; k++) begin
      set_req(k % N, ti[k]);
      expect_rsp("single", k % N, td[k], ti[k] + 2);
    end

    // Contention from reset, then pointer rotation
    reset = 1'b1;
    set_req(0, 4); set_req(1, 9);
    cycle();
    reset = 1'b0;
    expect_rsp("cont0", 0, 1, 6);
    expect_rsp("cont1", 1, 5, -1);
    set_req(0, 2);
    expect_rsp("rot_pre", 0, 1, 4);
    set_req(0, 7); set_req(1, 8);
    expect_rsp("rot_first", 1, 4, 10);
    expect_rsp("rot_second", 0, 3, -1);

    // Back-pressure
    rsp_ready = 1'b0;
    set_req(0, 6);
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin step(); got = obs_valid; end
    chk("bp_rise", 64'(got), 64'(1));
    set_req(1, 3);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("bp_hold_data", 64'(obs_data), 64'(2));
      chk("bp_hold_id", 64'(obs_id), 64'(0));
    end
    rsp_ready = 1'b1;
    step();
    step();
    chk("bp_idle_after", 64'(obs_busy), 64'(0));
    chk("bp_next_grant", 64'(m_hs), 64'(2));
    expect_rsp("bp_next", 1, 1, 5);

    // Wrap
    set_req(0, 255);
    expect_rsp("wrap", 0, sref[255], 257);

    // Reset mid-run: pointer left at 1 beforehand, must return to 0
    set_req(0, 1);
    expect_rsp("pre_rst", 0, 0, 3);
    set_req(0, 50);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin step(); got = m_hs[0]; end
    for (int c = 0; c < 4; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 60; c++) begin step(); if (obs_valid) cnt++; end
    chk("rst_no_rsp", 64'(cnt), 64'(0));
    set_req(0, 3); set_req(1, 5);
    expect_rsp("rst_ptr0", 0, 1, 5);
    expect_rsp("rst_ptr1", 1, 2, -1);

`ifdef SEQ_TERM_ARB_ABORT_EN
    set_req(0, 30);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin step(); got = m_hs[0]; end
    for (int c = 0; c < 3; c++) step();
    set_req(1, 4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    expect_rsp("abort_next", 1, 1, 6);
`endif

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) set_req(i, ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20));
        end else if ($urandom_range(0, 31) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 499) == 0);
`ifdef SEQ_TERM_ARB_ABORT_EN
      abort = ($urandom_range(0, 63) == 0);
`endif
      step();
    end
    reset = 1'b0; rsp_ready = 1'b1; abort = 1'b0; req_valid = '0;
    for (int c = 0; c < 300; c++) step();
    chk("drain_idle", 64'(obs_busy), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
